seq_window_streamer: RTL and testbench

//  Synthesizable sequence front-end: accepts an ASCII nucleotide stream (valid/ready), encodes A/C/G/T to 2 bits
//  and assembles overlapping windows (stride WINDOW_SIZE-KMER_SIZE+1). Drives window_hasher (window, ready_for_hashing,

---
 rtl/seq_window_streamer.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_window_streamer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_window_streamer.sv
// Front-end that turns an ASCII nucleotide stream into overlapping 2-bit windows and
// sequences the control pulses for window_hasher, hash_table and stats.
module seq_window_streamer #(
    parameter int WINDOW_SIZE              = 128,
    parameter int KMER_SIZE                = 16,
    parameter int MAX_WINDOWS_IN_REFERENCE = 512,
    parameter int PULSE_CYCLES             = 2
) (
    input  logic        clk,
    input  logic        reset_seq_window_streamer_n,
    input  logic        seq_start,
    input  logic        is_reference,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic        char_last,
    output logic        char_ready,
    output logic [1:0]  window [0:WINDOW_SIZE-1],
    output logic [31:0] window_id,
    output logic        ready_for_hashing,
    input  logic        hashing_is_done,
    output logic        reset_window_hasher,
    output logic        reset_stats,
    output logic        is_insert,
    output logic        is_query,
    output logic        calculate_matched_window,
    output logic        seq_done,
    output logic        bad_char,
    output logic        overflow
);
    localparam int FW     = $clog2(WINDOW_SIZE + 1);
    localparam int IW     = $clog2(WINDOW_SIZE);
    localparam int PW     = $clog2(PULSE_CYCLES + 1);
    localparam int STRIDE = WINDOW_SIZE - KMER_SIZE + 1;
    localparam logic [FW-1:0] FILL_LAST  = FW'(WINDOW_SIZE - 1);
    localparam logic [FW-1:0] KMER_KEEP  = FW'(KMER_SIZE - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES);
    localparam logic [31:0]   LAST_ID    = 32'(MAX_WINDOWS_IN_REFERENCE - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SRST   = 4'd1,
        ST_FILL   = 4'd2,
        ST_DRAIN  = 4'd3,
        ST_HASH   = 4'd4,
        ST_COMMIT = 4'd5,
        ST_HRST   = 4'd6,
        ST_CALC   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    // Bit 2 flags a legal uppercase nucleotide, bits 1:0 carry its code.
    function automatic logic [2:0] encode_nt(input logic [7:0] c);
        logic [2:0] r;
        case (c)
            8'h41:   r = 3'b100;
            8'h43:   r = 3'b101;
            8'h47:   r = 3'b110;
            8'h54:   r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d, end_state_s;
    logic [FW-1:0] fill_cnt_q, fill_cnt_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0]   window_id_q, window_id_d;
    logic          is_ref_q, is_ref_d, last_seen_q, last_seen_d;
    logic [1:0]    window_q [0:WINDOW_SIZE-1];
    logic [1:0]    window_d [0:WINDOW_SIZE-1];
    logic [2:0]    nt_s;
    logic          bad_char_d, overflow_d;
    logic          char_ready_q, rfh_q, rwh_q, rstats_q, insert_q, query_q, calc_q, done_q, bad_q, ovf_q;

    // Next-state and datapath update for the sequence controller.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        window_id_d = window_id_q;
        is_ref_d    = is_ref_q;
        last_seen_d = last_seen_q;
        window_d    = window_q;
        bad_char_d  = 1'b0;
        overflow_d  = 1'b0;
        nt_s        = encode_nt(char_data);
        end_state_s = is_ref_q ? ST_DONE : ST_CALC;
        case (state_q)
            ST_IDLE: begin
                if (seq_start) begin
                    is_ref_d    = is_reference;
                    window_id_d = 32'd0;
                    fill_cnt_d  = '0;
                    last_seen_d = 1'b0;
                    state_d     = ST_SRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SRST, ST_HRST, ST_CALC: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = (state_q == ST_CALC) ? ST_DONE : ST_FILL;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
            ST_FILL: begin
                if (char_valid && nt_s[2]) begin
                    window_d[fill_cnt_q[IW-1:0]] = nt_s[1:0];
                    fill_cnt_d = fill_cnt_q + FW'(1);
                    if (fill_cnt_q == FILL_LAST) begin
                        last_seen_d = char_last;
                        state_d     = ST_HASH;
                    end else if (char_last) begin
                        state_d = end_state_s;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (char_valid) begin
                    bad_char_d = 1'b1;
                    state_d    = char_last ? end_state_s : ST_DRAIN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (char_valid && char_last) begin
                    state_d = end_state_s;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HASH: begin
                if (hashing_is_done) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_HASH;
                end
            end
            ST_COMMIT: begin
                if (pulse_cnt_q != PULSE_LAST) begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end else if (last_seen_q) begin
                    state_d = end_state_s;
                end else if (window_id_q == LAST_ID) begin
                    overflow_d = 1'b1;
                    state_d    = ST_DRAIN;
                end else begin
                    // Carry the k-1 overlap to the head of the next window.
                    for (int i = 0; i < KMER_SIZE - 1; i++) begin
                        window_d[IW'(i)] = window_q[IW'(i + STRIDE)];
                    end
                    window_id_d = window_id_q + 32'd1;
                    fill_cnt_d  = KMER_KEEP;
                    state_d     = ST_HRST;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            pulse_cnt_d = PW'(1);
        end else begin
            pulse_cnt_d = pulse_cnt_d;
        end
    end

    // State, datapath and output registers; outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_seq_window_streamer_n) begin
            state_q      <= ST_IDLE;
            fill_cnt_q   <= '0;
            pulse_cnt_q  <= '0;
            window_id_q  <= 32'd0;
            is_ref_q     <= 1'b0;
            last_seen_q  <= 1'b0;
            window_q     <= '{default: 2'b00};
            char_ready_q <= 1'b0;
            rfh_q        <= 1'b0;
            rwh_q        <= 1'b0;
            rstats_q     <= 1'b0;
            insert_q     <= 1'b0;
            query_q      <= 1'b0;
            calc_q       <= 1'b0;
            done_q       <= 1'b0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            window_id_q  <= window_id_d;
            is_ref_q     <= is_ref_d;
            last_seen_q  <= last_seen_d;
            window_q     <= window_d;
            char_ready_q <= (state_d == ST_FILL) || (state_d == ST_DRAIN);
            rfh_q        <= (state_d == ST_HASH);
            rwh_q        <= (state_d == ST_SRST) || (state_d == ST_HRST);
            rstats_q     <= (state_d == ST_SRST);
            insert_q     <= (state_d == ST_COMMIT) && is_ref_d;
            query_q      <= (state_d == ST_COMMIT) && !is_ref_d;
            calc_q       <= (state_d == ST_CALC);
            done_q       <= (state_d == ST_DONE);
            bad_q        <= bad_char_d;
            ovf_q        <= overflow_d;
        end
    end

    assign char_ready               = char_ready_q;
    assign window                   = window_q;
    assign window_id                = window_id_q;
    assign ready_for_hashing        = rfh_q;
    assign reset_window_hasher      = rwh_q;
    assign reset_stats              = rstats_q;
    assign is_insert                = insert_q;
    assign is_query                 = query_q;
    assign calculate_matched_window = calc_q;
    assign seq_done                 = done_q;
    assign bad_char                 = bad_q;
    assign overflow                 = ovf_q;
endmodule

// File: tb/tb_seq_window_streamer.sv
// Randomized bench for seq_window_streamer: each sequence is compared against a model
// that slices the character string into stride-spaced windows.
module tb_seq_window_streamer;
    localparam int WS = 128, KS = 16, MAXW = 512, PC = 2, STRIDE = WS - KS + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seq_start = 1'b0, is_reference = 1'b0;
    logic        char_valid = 1'b0, char_last = 1'b0;
    logic [7:0]  char_data = 8'd0;
    logic        hashing_is_done = 1'b0;
    logic        char_ready, ready_for_hashing, reset_window_hasher, reset_stats;
    logic        is_insert, is_query, calculate_matched_window, seq_done, bad_char, overflow;
    logic [1:0]  win_s [0:WS-1];
    logic [31:0] window_id;

    int    checks = 0, errors = 0;
    byte   seq_q[$];
    string nuc = "ACGT";

    seq_window_streamer #(
        .WINDOW_SIZE(WS), .KMER_SIZE(KS), .MAX_WINDOWS_IN_REFERENCE(MAXW), .PULSE_CYCLES(PC)
    ) dut (
        .clk(clk), .reset_seq_window_streamer_n(rst_n), .seq_start(seq_start),
        .is_reference(is_reference), .char_valid(char_valid), .char_data(char_data),
        .char_last(char_last), .char_ready(char_ready), .window(win_s), .window_id(window_id),
        .ready_for_hashing(ready_for_hashing), .hashing_is_done(hashing_is_done),
        .reset_window_hasher(reset_window_hasher), .reset_stats(reset_stats),
        .is_insert(is_insert), .is_query(is_query),
        .calculate_matched_window(calculate_matched_window), .seq_done(seq_done),
        .bad_char(bad_char), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int code_of(input byte c);
        int r = 4;
        for (int j = 0; j < 4; j++) if (c == nuc[j]) r = j;
        return r;
    endfunction

    function automatic logic [255:0] pack_window();
        logic [255:0] p;
        for (int i = 0; i < WS; i++) p[2*i +: 2] = win_s[i];
        return p;
    endfunction

    task automatic gen_seq(input int n, input bit all_a);
        seq_q.delete();
        for (int i = 0; i < n; i++) seq_q.push_back(all_a ? nuc[0] : nuc[$urandom_range(0, 3)]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_outputs"}, {char_ready, ready_for_hashing, reset_window_hasher, reset_stats,
              is_insert, is_query, calculate_matched_window, seq_done, bad_char, overflow}, 10'd0);
        check({tag, "_window_id"}, window_id, 32'd0);
        check({tag, "_window"}, pack_window(), 256'd0);
    endtask

    task automatic run_seq(input bit is_ref, input int hash_delay, input int abort_hash, output bit aborted);
        int n = seq_q.size();
        int bad_pos = n;
        int k_win = 0, hrst = 0, last_idx;
        bit exp_bad, exp_ovf, cv;
        logic [255:0] exp_win[$];
        logic [255:0] w, cur, snap;
        int idx = 0, cyc = 0, hcnt = 0, crun = 0;
        int rfh_cnt = 0, commit_cnt = 0, rwh_cyc = 0, rs_cyc = 0, calc_cyc = 0;
        int bad_cnt = 0, ovf_cnt = 0, done_cnt = 0;
        logic [31:0] cid = 32'd0;
        bit prev_rfh = 1'b0, prev_commit = 1'b0, stable_ok = 1'b1;

        // Model: window k is chars [k*STRIDE, k*STRIDE+WS-1], kept only if it ends before the first bad char.
        for (int i = 0; i < n; i++) if (bad_pos == n && code_of(seq_q[i]) > 3) bad_pos = i;
        while (k_win < MAXW && k_win * STRIDE + WS <= bad_pos) begin
            for (int i = 0; i < WS; i++) w[2*i +: 2] = 2'(code_of(seq_q[k_win * STRIDE + i]));
            exp_win.push_back(w);
            last_idx = k_win * STRIDE + WS - 1;
            if (last_idx != n - 1 && k_win != MAXW - 1) hrst++;
            k_win++;
        end
        exp_ovf = (k_win == MAXW) && ((MAXW - 1) * STRIDE + WS - 1 != n - 1);
        exp_bad = (bad_pos < n) && !(exp_ovf && bad_pos > (MAXW - 1) * STRIDE + WS - 1);

        aborted = 1'b0;
        @(negedge clk);
        seq_start = 1'b1;
        is_reference = is_ref;
        while (done_cnt == 0 && !aborted && cyc < 10 * n + 200) begin
            @(negedge clk);
            cyc++;
            cur = pack_window();
            if (ready_for_hashing) begin
                if (!prev_rfh) begin
                    snap = cur;
                    hcnt = 0;
                    if (rfh_cnt < k_win) check($sformatf("window%0d", rfh_cnt), cur, exp_win[rfh_cnt]);
                end
                hcnt++;
                if (cur !== snap || char_ready !== 1'b0) stable_ok = 1'b0;
                if (abort_hash > 0 && hcnt == abort_hash) aborted = 1'b1;
            end else if (prev_rfh) begin
                check("hash_len", hcnt, hash_delay + 1);
                rfh_cnt++;
            end
            prev_rfh = ready_for_hashing;
            hashing_is_done = ready_for_hashing && hcnt > hash_delay;

            if (is_insert || is_query) begin
                if (!prev_commit) begin
                    cid = window_id;
                    crun = 0;
                    check("commit_kind", {is_insert, is_query}, is_ref ? 2'b10 : 2'b01);
                    check("commit_id", window_id, commit_cnt);
                end
                crun++;
                if (window_id !== cid) stable_ok = 1'b0;
            end else if (prev_commit) begin
                check("commit_len", crun, PC);
                commit_cnt++;
            end
            prev_commit = is_insert || is_query;
            if (reset_window_hasher) rwh_cyc++;
            if (reset_stats) rs_cyc++;
            if (calculate_matched_window) calc_cyc++;
            if (bad_char) bad_cnt++;
            if (overflow) ovf_cnt++;
            if (seq_done) done_cnt++;

            // Stray seq_start and a flipped is_reference must be ignored outside IDLE.
            seq_start = (done_cnt == 0 && !aborted) ? 1'($urandom_range(0, 5) == 0) : 1'b0;
            is_reference = ~is_ref;
            cv = !aborted && idx < n && $urandom_range(0, 3) != 0;
            char_valid = cv;
            char_data = cv ? seq_q[idx] : 8'($urandom);
            char_last = cv && idx == n - 1;
            if (cv && char_ready) idx++;
        end
        seq_start = 1'b0;
        char_valid = 1'b0;
        char_last = 1'b0;
        hashing_is_done = 1'b0;
        is_reference = 1'b0;
        if (!aborted) begin
            check("seq_done_count", done_cnt, 1);
            check("hash_count", rfh_cnt, k_win);
            check("commit_count", commit_cnt, k_win);
            check("reset_stats_cycles", rs_cyc, PC);
            check("reset_hasher_cycles", rwh_cyc, PC * (1 + hrst));
            check("calc_cycles", calc_cyc, is_ref ? 0 : PC);
            check("bad_char_count", bad_cnt, exp_bad);
            check("overflow_count", ovf_cnt, exp_ovf);
            check("chars_accepted", idx, n);
            check("hold_stable", stable_ok, 1'b1);
        end
    endtask

    initial begin
        bit ab;
        int n;
        byte bad_chars[3];
        bad_chars[0] = 8'h4E;
        bad_chars[1] = 8'h61;
        bad_chars[2] = 8'h78;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        rst_n = 1'b1;

        gen_seq(128, 1'b1); run_seq(1'b1, 0, 0, ab);
        gen_seq(241, 1'b0); run_seq(1'b1, 1, 0, ab);
        gen_seq(200, 1'b0); run_seq(1'b0, 2, 0, ab);
        gen_seq(101, 1'b0); seq_q[50] = 8'h4E; run_seq(1'b0, 0, 0, ab);
        gen_seq(128, 1'b0); run_seq(1'b0, 10, 0, ab);

        gen_seq(128, 1'b0); run_seq(1'b1, 5, 3, ab);
        check("abort_in_hash", ab, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("hash_reset");
        @(negedge clk);
        rst_n = 1'b1;
        gen_seq(128, 1'b1); run_seq(1'b1, 0, 0, ab);

        gen_seq(5, 1'b0); run_seq(1'b0, 0, 0, ab);
        gen_seq(130, 1'b0); seq_q[129] = 8'h61; run_seq(1'b1, 1, 0, ab);
        gen_seq(354, 1'b0); run_seq(1'b0, 3, 0, ab);

        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 360);
            gen_seq(n, 1'b0);
            if ($urandom_range(0, 2) == 0) seq_q[$urandom_range(0, n - 1)] = bad_chars[$urandom_range(0, 2)];
            run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
